// File: rtl/nco_sweep_pkg.sv
// nco_sweep_pkg: shared types and default widths for the NCO sweep sequencer.
// Provides the sweep FSM state enum and APR/NPW/DWW default widths.
package nco_sweep_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      DWELL,
      STEP
   } sweep_state_t;

   localparam int APR_W = 32;
   localparam int NPW_W = 16;
   localparam int DWW_W = 24;

endpackage

// File: rtl/sweep_dwell_cnt.sv
// sweep_dwell_cnt: loadable down-counter with zero flag, shared by SETTLE and DWELL.
// Ports: clk, reset_n, load/load_val (load wins), dec (count down), zero (count==0).
module sweep_dwell_cnt
   import nco_sweep_pkg::*;
#(
   parameter int DWW = DWW_W
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           load,
   input  logic [DWW-1:0] load_val,
   input  logic           dec,
   output logic           zero
);

   logic [DWW-1:0] count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && !zero) begin
         count <= count - DWW'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl: steps the NCO phase increment across N equally spaced points,
// with a settle interval then a measurement window at each point.
// Ports: clk, reset_n, start, abort, f_start, f_step, n_points, dwell (config in);
//        phi_inc_o, nco_clken, meas_en, point_done, point_idx, busy, done (out).
module nco_sweep_ctrl
   import nco_sweep_pkg::*;
#(
   parameter int APR        = APR_W,
   parameter int NPW        = NPW_W,
   parameter int DWW        = DWW_W,
   parameter int SETTLE_CYC = 8
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           start,
   input  logic           abort,
   input  logic [APR-1:0] f_start,
   input  logic [APR-1:0] f_step,
   input  logic [NPW-1:0] n_points,
   input  logic [DWW-1:0] dwell,
   output logic [APR-1:0] phi_inc_o,
   output logic           nco_clken,
   output logic           meas_en,
   output logic           point_done,
   output logic [NPW-1:0] point_idx,
   output logic           busy,
   output logic           done
);

   localparam logic [DWW-1:0] SET_LD = DWW'(SETTLE_CYC - 1);

   sweep_state_t   state;
   sweep_state_t   state_nx;

   logic [APR-1:0] step_sh;
   logic [NPW-1:0] npts_sh;
   logic [DWW-1:0] dwell_sh;

   logic           cnt_load;
   logic [DWW-1:0] cnt_val;
   logic           cnt_dec;
   logic           cnt_zero;

   logic           go;
   logic           empty;
   logic           last;
   logic           fin;

   assign go    = (state == IDLE) && start && !abort && (n_points != '0);
   assign empty = (state == IDLE) && start && !abort && (n_points == '0);
   assign last  = (point_idx == npts_sh - NPW'(1));
   assign fin   = (state == DWELL) && cnt_zero && last;

   assign cnt_dec    = (state == SETTLE) || (state == DWELL);
   assign meas_en    = (state == DWELL);
   // An abort in the final dwell cycle cancels that point's completion event.
   assign point_done = (state == DWELL) && cnt_zero && !abort;
   assign nco_clken  = busy;

   sweep_dwell_cnt #(
      .DWW (DWW)
   ) u_cnt (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (cnt_load),
      .load_val (cnt_val),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   always_comb begin
      state_nx = state;
      cnt_load = 1'b0;
      cnt_val  = SET_LD;
      if (abort) begin
         state_nx = IDLE;
      end else begin
         unique case (state)
            IDLE: begin
               if (go) begin
                  state_nx = SETTLE;
                  cnt_load = 1'b1;
               end
            end
            SETTLE: begin
               if (cnt_zero) begin
                  state_nx = DWELL;
                  cnt_load = 1'b1;
                  cnt_val  = dwell_sh - DWW'(1);
               end
            end
            DWELL: begin
               if (cnt_zero) begin
                  state_nx = last ? IDLE : STEP;
               end
            end
            STEP: begin
               state_nx = SETTLE;
               cnt_load = 1'b1;
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Datapath: phase word, index, shadows and status flags.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         phi_inc_o <= '0;
         point_idx <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         step_sh   <= '0;
         npts_sh   <= '0;
         dwell_sh  <= '0;
      end else begin
         done <= 1'b0;
         if (abort) begin
            busy <= 1'b0;
         end else begin
            unique case (1'b1)
               go: begin
                  step_sh   <= f_step;
                  npts_sh   <= n_points;
                  dwell_sh  <= (dwell == '0) ? DWW'(1) : dwell;
                  phi_inc_o <= f_start;
                  point_idx <= '0;
                  busy      <= 1'b1;
               end
               empty: begin
                  done <= 1'b1;
               end
               fin: begin
                  busy <= 1'b0;
                  done <= 1'b1;
               end
               (state == STEP): begin
                  phi_inc_o <= phi_inc_o + step_sh;
                  point_idx <= point_idx + NPW'(1);
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// tb_nco_sweep_ctrl: self-checking bench for nco_sweep_ctrl (SETTLE_CYC=4).
// Table-driven sweeps, randomized sweeps against a per-cycle model, corner sequences.
module tb_nco_sweep_ctrl;

   localparam int S = 4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [31:0] f_start = '0;
   logic [31:0] f_step = '0;
   logic [15:0] n_points = '0;
   logic [23:0] dwell = '0;
   logic [31:0] phi_inc_o;
   logic        nco_clken;
   logic        meas_en;
   logic        point_done;
   logic [15:0] point_idx;
   logic        busy;
   logic        done;

   nco_sweep_ctrl #(
      .APR        (32),
      .NPW        (16),
      .DWW        (24),
      .SETTLE_CYC (S)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .abort      (abort),
      .f_start    (f_start),
      .f_step     (f_step),
      .n_points   (n_points),
      .dwell      (dwell),
      .phi_inc_o  (phi_inc_o),
      .nco_clken  (nco_clken),
      .meas_en    (meas_en),
      .point_done (point_done),
      .point_idx  (point_idx),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] fs;
      logic [31:0] st;
      logic [15:0] n;
      logic [23:0] dw;
   } cfg_t;

   typedef struct {
      logic [31:0] phi;
      logic [15:0] idx;
      logic        busy;
      logic        meas;
      logic        pd;
      logic        done;
   } exp_t;

   typedef struct {
      cfg_t            c;
      int              nbusy;
      int              nmeas;
      int              npd;
      logic [2:0][31:0] ph;
   } tab_t;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] hold_phi = '0;
   logic [15:0] hold_idx = '0;

   int          r_busy, r_meas, r_pd, r_done_k;
   logic [31:0] r_ph [3];

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got %0h expected %0h", nm, got, exp);
      end
   endtask

   function automatic int busy_len(input cfg_t c);
      int d;
      d = (c.dw == 0) ? 1 : int'(c.dw);
      return int'(c.n) * (S + d) + int'(c.n) - 1;
   endfunction

   // Expected outputs in cycle k after the start-sampling edge.
   function automatic exp_t model(input cfg_t c, input int k);
      exp_t e;
      int   d, per, tb, p, o;
      d   = (c.dw == 0) ? 1 : int'(c.dw);
      per = S + d + 1;
      tb  = busy_len(c);
      e.phi  = hold_phi;
      e.idx  = hold_idx;
      e.busy = 1'b0;
      e.meas = 1'b0;
      e.pd   = 1'b0;
      e.done = 1'b0;
      if (c.n == 0) begin
         e.done = (k == 1);
      end else if (k <= tb) begin
         p = (k - 1) / per;
         o = (k - 1) % per;
         e.busy = 1'b1;
         e.phi  = c.fs + 32'(p) * c.st;
         e.idx  = 16'(p);
         e.meas = (o >= S) && (o < S + d);
         e.pd   = (o == S + d - 1);
      end else begin
         e.phi  = c.fs + 32'(int'(c.n) - 1) * c.st;
         e.idx  = c.n - 16'd1;
         e.done = (k == tb + 1);
      end
      return e;
   endfunction

   task automatic scramble();
      f_start  = $urandom;
      f_step   = $urandom;
      n_points = 16'($urandom);
      dwell    = 24'($urandom);
   endtask

   task automatic kick(input cfg_t c);
      @(negedge clk);
      f_start  = c.fs;
      f_step   = c.st;
      n_points = c.n;
      dwell    = c.dw;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      scramble();
   endtask

   task automatic run_model(input cfg_t c, input bit junk);
      exp_t e;
      int   tb;
      tb = busy_len(c);
      kick(c);
      for (int k = 1; k <= tb + 3; k++) begin
         e = model(c, k);
         chk("model_cyc",
             {phi_inc_o, point_idx, busy, nco_clken, meas_en, point_done, done},
             {e.phi, e.idx, e.busy, e.busy, e.meas, e.pd, e.done});
         if (junk && k <= tb) begin
            start = 1'($urandom);
            scramble();
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      if (c.n != 0) begin
         hold_phi = c.fs + 32'(int'(c.n) - 1) * c.st;
         hold_idx = c.n - 16'd1;
      end
   endtask

   task automatic run_tab(input cfg_t c);
      r_busy   = 0;
      r_meas   = 0;
      r_pd     = 0;
      r_done_k = -1;
      kick(c);
      for (int k = 1; k <= 200; k++) begin
         if (busy) r_busy++;
         if (meas_en) r_meas++;
         if (point_done) begin
            if (r_pd < 3) r_ph[r_pd] = phi_inc_o;
            r_pd++;
         end
         if (done) begin
            r_done_k = k;
            break;
         end
         @(negedge clk);
      end
   endtask

   function automatic tab_t mk(input logic [31:0] fs, input logic [31:0] st,
                               input logic [15:0] n, input logic [23:0] dw,
                               input int nb, input int nm, input int np,
                               input logic [31:0] p0, input logic [31:0] p1,
                               input logic [31:0] p2);
      tab_t t;
      t.c.fs  = fs;
      t.c.st  = st;
      t.c.n   = n;
      t.c.dw  = dw;
      t.nbusy = nb;
      t.nmeas = nm;
      t.npd   = np;
      t.ph[0] = p0;
      t.ph[1] = p1;
      t.ph[2] = p2;
      return t;
   endfunction

   tab_t tab [5];
   cfg_t cr;

   initial begin
      tab[0] = mk(32'h0100_0000, 32'h0010_0000, 16'd3, 24'd5, 29, 15, 3,
                  32'h0100_0000, 32'h0110_0000, 32'h0120_0000);
      tab[1] = mk(32'hFFFF_FFF0, 32'h0000_0020, 16'd2, 24'd3, 15, 6, 2,
                  32'hFFFF_FFF0, 32'h0000_0010, 32'h0);
      tab[2] = mk(32'h1234_5678, 32'h0000_0001, 16'd2, 24'd0, 11, 2, 2,
                  32'h1234_5678, 32'h1234_5679, 32'h0);
      tab[3] = mk(32'hDEAD_BEEF, 32'h0000_0100, 16'd0, 24'd5, 0, 0, 0,
                  32'h0, 32'h0, 32'h0);
      tab[4] = mk(32'hAAAA_0000, 32'h1111_1111, 16'd1, 24'd1, 5, 1, 1,
                  32'hAAAA_0000, 32'h0, 32'h0);

      repeat (3) @(negedge clk);
      chk("reset_state",
          {phi_inc_o, point_idx, busy, nco_clken, meas_en, point_done, done}, '0);
      reset_n = 1'b1;

      for (int i = 0; i < 5; i++) begin
         run_tab(tab[i].c);
         chk("busy_cycles", 64'(r_busy), 64'(tab[i].nbusy));
         chk("meas_cycles", 64'(r_meas), 64'(tab[i].nmeas));
         chk("point_done_cnt", 64'(r_pd), 64'(tab[i].npd));
         chk("done_cycle", 64'(r_done_k), 64'(tab[i].nbusy + 1));
         for (int j = 0; j < r_pd && j < 3; j++) begin
            chk("point_phi", r_ph[j], tab[i].ph[j]);
         end
         if (tab[i].c.n != 0) begin
            hold_phi = tab[i].ph[int'(tab[i].c.n) - 1];
            hold_idx = tab[i].c.n - 16'd1;
         end
      end

      for (int i = 0; i < 8; i++) begin
         cr.fs = $urandom;
         cr.st = $urandom;
         cr.n  = 16'($urandom_range(0, 4));
         cr.dw = 24'($urandom_range(0, 6));
         run_model(cr, 1'b1);
      end

      // Abort on the second dwell cycle of point 1.
      cr.fs = 32'h0200_0000;
      cr.st = 32'h0100_0000;
      cr.n  = 16'd4;
      cr.dw = 24'd5;
      kick(cr);
      repeat (15) @(negedge clk);
      chk("abort_pre_meas", {meas_en, point_idx}, {1'b1, 16'd1});
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_flags", {busy, nco_clken, meas_en, point_done, done}, 5'b0);
      chk("abort_hold", {phi_inc_o, point_idx}, {32'h0300_0000, 16'd1});
      r_busy = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         r_busy += int'(busy) + int'(done);
      end
      chk("abort_quiet", 64'(r_busy), 64'd0);
      hold_phi = 32'h0300_0000;
      hold_idx = 16'd1;

      // start together with abort in IDLE, for both non-empty and empty sweeps.
      @(negedge clk);
      start    = 1'b1;
      abort    = 1'b1;
      n_points = 16'd3;
      @(negedge clk);
      chk("start_abort_n3", {busy, done, meas_en}, 3'b0);
      n_points = 16'd0;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      chk("start_abort_n0", {busy, done}, 2'b0);
      @(negedge clk);
      chk("start_abort_idle", {busy, done, phi_inc_o}, {2'b0, hold_phi});

      // Reset while in SETTLE, then a full sweep from point 0.
      cr.fs = 32'h5555_0000;
      cr.st = 32'h0000_1000;
      cr.n  = 16'd2;
      cr.dw = 24'd3;
      kick(cr);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("reset_mid",
          {phi_inc_o, point_idx, busy, nco_clken, meas_en, point_done, done}, '0);
      @(negedge clk);
      reset_n  = 1'b1;
      hold_phi = '0;
      hold_idx = '0;
      run_model(cr, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
